// File: rtl/pipe_pkg.sv
// pipe_pkg: shared fetch-state encoding and register constants for the pipeline controller
package pipe_pkg;
    typedef enum logic [1:0] {RUN, WAIT, DISCARD} fetch_state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs and stage-register controls between datapath and controller
interface pipeline_ctrl_if;
    logic [4:0] ID_rs1;
    logic [4:0] ID_rs2;
    logic       ID_use_rs1;
    logic       ID_use_rs2;
    logic       EX_mem_read;
    logic [4:0] EX_rd;
    logic       EX_redirect;
    logic       im_valid;
    logic       dm_busy;
    logic       pc_write;
    logic       IFID_write;
    logic       IFID_flush;
    logic       IDEX_write;
    logic       EXMEM_write;
    logic       IDEX_flush;
    logic       MEMWB_bubble;
    modport master (
        output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_mem_read, EX_rd,
               EX_redirect, im_valid, dm_busy,
        input  pc_write, IFID_write, IFID_flush, IDEX_write, EXMEM_write,
               IDEX_flush, MEMWB_bubble
    );
    modport slave (
        input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_mem_read, EX_rd,
               EX_redirect, im_valid, dm_busy,
        output pc_write, IFID_write, IFID_flush, IDEX_write, EXMEM_write,
               IDEX_flush, MEMWB_bubble
    );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: flags a load in EX whose destination is read by the instruction in ID
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic       mem_read,
    input  logic [4:0] rd,
    output logic       lu
);
    assign lu = mem_read && rd != REG_ZERO &&
                ((use_rs1 && rs1 == rd) || (use_rs2 && rs2 == rd));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: prioritised stall/flush control, fetch discard FSM and saturating activity counters
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int FLUSH_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pipeline_ctrl_if.slave         p,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [FLUSH_CNT_W-1:0] flush_cnt
);
    fetch_state_t state, state_n;
    logic         lu;
    logic [6:0]   ctl;
    hazard_detect u_hd (
        .rs1      (p.ID_rs1),
        .rs2      (p.ID_rs2),
        .use_rs1  (p.ID_use_rs1),
        .use_rs2  (p.ID_use_rs2),
        .mem_read (p.EX_mem_read),
        .rd       (p.EX_rd),
        .lu       (lu)
    );
    // {pc_write, IFID_write, IFID_flush, IDEX_write, EXMEM_write, IDEX_flush, MEMWB_bubble}
    always_comb begin
        ctl = !reset_n                ? 7'b0000000 :
              p.dm_busy               ? 7'b0000001 :
              p.EX_redirect           ? 7'b1111110 :
              state == DISCARD        ? 7'b0111100 :
              lu                      ? 7'b0001110 :
              !p.im_valid             ? 7'b0111100 :
                                        7'b1101100;
        state_n = p.dm_busy           ? state :
                  p.EX_redirect       ? ((!p.im_valid && state != DISCARD) ? DISCARD : RUN) :
                  state == DISCARD    ? (p.im_valid ? RUN : DISCARD) :
                  lu                  ? state :
                  !p.im_valid         ? WAIT : RUN;
    end
    assign {p.pc_write, p.IFID_write, p.IFID_flush, p.IDEX_write,
            p.EXMEM_write, p.IDEX_flush, p.MEMWB_bubble} = ctl;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_n;
            if (!p.pc_write && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (p.EX_redirect && !p.dm_busy && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed steps with a scoreboard of expected controls and counter values
module tb_pipeline_ctrl;
    import pipe_pkg::*;
    localparam logic [6:0] N = 7'b1101100;
    localparam logic [6:0] R = 7'b1111110;
    localparam logic [6:0] D = 7'b0111100;
    localparam logic [6:0] L = 7'b0001110;
    localparam logic [6:0] B = 7'b0000001;
    localparam logic [6:0] Z = 7'b0000000;
    typedef struct {
        string       tag;
        logic [6:0]  ctl;
        logic [3:0]  sc;
        logic [15:0] fc;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  stall_cnt;
    logic [15:0] flush_cnt;
    logic [6:0]  ctl_obs;
    logic [3:0]  m_stall = '0;
    logic [15:0] m_flush = '0;
    int          errors = 0;
    int          checks = 0;
    exp_t        q[$];
    always #5 clk = ~clk;
    pipeline_ctrl_if bus ();
    pipeline_ctrl #(.CNT_W(4), .FLUSH_CNT_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .p         (bus),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
    assign ctl_obs = {bus.pc_write, bus.IFID_write, bus.IFID_flush, bus.IDEX_write,
                      bus.EXMEM_write, bus.IDEX_flush, bus.MEMWB_bubble};
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks += 3;
            assert (ctl_obs === e.ctl) else begin
                errors++;
                $error("FAIL %s ctl got %b expected %b", e.tag, ctl_obs, e.ctl);
            end
            assert (stall_cnt === e.sc) else begin
                errors++;
                $error("FAIL %s stall_cnt got %0d expected %0d", e.tag, stall_cnt, e.sc);
            end
            assert (flush_cnt === e.fc) else begin
                errors++;
                $error("FAIL %s flush_cnt got %0d expected %0d", e.tag, flush_cnt, e.fc);
            end
        end
    end
    task automatic step(input string tag, input logic rn, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                        input logic redir, input logic imv, input logic busy, input logic [6:0] ectl);
        @(posedge clk);
        #1;
        reset_n = rn;
        bus.ID_rs1 = rs1;
        bus.ID_rs2 = rs2;
        bus.ID_use_rs1 = u1;
        bus.ID_use_rs2 = u2;
        bus.EX_mem_read = mr;
        bus.EX_rd = rd;
        bus.EX_redirect = redir;
        bus.im_valid = imv;
        bus.dm_busy = busy;
        if (!rn) begin
            m_stall = '0;
            m_flush = '0;
        end
        q.push_back('{tag, ectl, m_stall, m_flush});
        if (rn && !ectl[6] && m_stall != 4'hF) m_stall = m_stall + 1'b1;
        if (rn && redir && !busy) m_flush = m_flush + 1'b1;
    endtask
    task automatic idle(input string tag, input logic imv, input logic [6:0] ectl);
        step(tag, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, imv, 1'b0, ectl);
    endtask
    task automatic rst(input string tag);
        step(tag, 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, Z);
    endtask
    initial begin
        bus.ID_rs1 = '0; bus.ID_rs2 = '0; bus.ID_use_rs1 = 0; bus.ID_use_rs2 = 0;
        bus.EX_mem_read = 0; bus.EX_rd = '0; bus.EX_redirect = 0; bus.im_valid = 0; bus.dm_busy = 0;
        rst("reset0");
        rst("reset1");
        idle("run", 1'b1, N);
        step("lu_rs1", 1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, L);
        idle("lu_resume", 1'b1, N);
        idle("lu_cnt", 1'b1, N);
        step("x0_load", 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, N);
        step("lu_rs2", 1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, L);
        step("rs2_unused", 1'b1, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, N);
        step("redir_lu", 1'b1, 5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, R);
        idle("redir_run", 1'b1, N);
        rst("reset2");
        step("redir_miss", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, R);
        idle("discard_wait", 1'b0, D);
        step("discard_drop", 1'b1, 5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, D);
        idle("after_discard", 1'b1, N);
        idle("wait_enter", 1'b0, D);
        step("wait_lu", 1'b1, 5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, L);
        idle("wait_done", 1'b1, N);
        rst("reset3");
        for (int i = 0; i < 3; i++)
            step("busy_hold", 1'b1, 5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, B);
        step("busy_redir", 1'b1, 5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, R);
        idle("busy_after", 1'b1, N);
        rst("reset4");
        for (int i = 0; i < 20; i++)
            step("sat_busy", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, B);
        idle("sat_hold", 1'b1, N);
        idle("sat_hold2", 1'b0, D);
        idle("sat_hold3", 1'b1, N);
        rst("reset5");
        step("rd_redir", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, R);
        idle("rd_discard", 1'b0, D);
        rst("rd_reset");
        idle("rd_release", 1'b1, N);
        idle("rd_run", 1'b1, N);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
